// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and width defaults.
package inst_loader_pkg;

  localparam int WORD_DEF = 32;
  localparam int ADDR_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/inst_loader.sv
// Streams a program into instruction memory, holding the core until the last word is written,
// then hands the memory address port back to the core's fetch address.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int WORD = WORD_DEF,
  parameter int ADDR = ADDR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [ADDR:0]   len_i,
  input  logic            s_valid_i,
  input  logic [WORD-1:0] s_data_i,
  output logic            s_ready_o,
  input  logic [ADDR-1:0] core_addr_i,
  output logic [ADDR-1:0] mem_addr_o,
  output logic            mem_write_o,
  output logic [WORD-1:0] mem_data_o,
  output logic            core_hold_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [WORD-1:0] checksum_o,
  output state_t          dbg_state_o
);

  localparam logic [ADDR:0] DEPTH = {1'b1, {ADDR{1'b0}}};

  state_t          state;
  logic [ADDR:0]   n_q;
  logic [ADDR:0]   count_q;
  logic [ADDR-1:0] wr_addr_q;
  logic [ADDR:0]   len_sat;
  logic            hs;
  logic            loading;

  // Stream handshake: a word moves when s_valid_i & s_ready_o are both high at a rising edge.
  // s_ready_o depends on registered state only, so it never waits on s_valid_i.
  assign len_sat     = (len_i > DEPTH) ? DEPTH : len_i;
  assign loading     = (state == S_LOAD) || (state == S_DRAIN);
  assign s_ready_o   = (state == S_LOAD) && (count_q < n_q);
  assign hs          = s_valid_i && s_ready_o;
  assign busy_o      = loading;
  assign mem_addr_o  = loading ? wr_addr_q : core_addr_i;
  assign dbg_state_o = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      n_q         <= '0;
      count_q     <= '0;
      wr_addr_q   <= '0;
      mem_write_o <= 1'b0;
      mem_data_o  <= '0;
      checksum_o  <= '0;
      core_hold_o <= 1'b1;
      done_o      <= 1'b0;
    end else begin
      mem_write_o <= 1'b0;
      done_o      <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (start_i) begin
            n_q        <= len_sat;
            count_q    <= '0;
            wr_addr_q  <= '0;
            checksum_o <= '0;
            if (len_sat == '0) begin
              state       <= S_RUN;
              core_hold_o <= 1'b0;
              done_o      <= 1'b1;
            end else begin
              state       <= S_LOAD;
              core_hold_o <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (hs) begin
            // count_q doubles as the next write address; it stops at DEPTH so the address never wraps.
            mem_write_o <= 1'b1;
            wr_addr_q   <= count_q[ADDR-1:0];
            mem_data_o  <= s_data_i;
            count_q     <= count_q + 1'b1;
            checksum_o  <= checksum_o ^ s_data_i;
            if (count_q == n_q - 1'b1) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state       <= S_RUN;
          core_hold_o <= 1'b0;
          done_o      <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
